mprj_logic_high_seq: RTL

Parametrised successor to the single-bit user-area tie-high cell. It drives CHANNELS groups of CH_WIDTH logic-high enable bits, one group per channel, into the user project area. Groups are released only after a debounced user-domain power-good. They are released one channel at a time, STAGGER cycles apart, to limit simultaneous switching on the enable nets. The block sits between the management-side power monitor and the user-area IO/logic-analyser enable gating.

---
 rtl/mprj_logic_high_seq.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mprj_logic_high_seq.sv
// ---------------------------------------------------------------------------
// mprj_logic_high_seq
//
// Purpose:
//   Sequenced logic-high enable source for the user project area. The block
//   drives CHANNELS groups of CH_WIDTH enable bits. A group is released only
//   after the user-domain power-good has been synchronised and then seen
//   high for PG_DEBOUNCE consecutive cycles. Groups are released one at a
//   time, STAGGER cycles apart, so that the enable nets do not all switch
//   on the same edge. Loss of power-good drops everything at once. A
//   software hold forces the enables down and keeps them down.
//
// Ports:
//   wb_clk_i    in   1                    clock
//   wb_rst_i    in   1                    synchronous active-high reset
//   pwr_good_i  in   1                    user-domain power good (async)
//   hold_i      in   1                    software hold (ramp-down, block)
//   HI          out  CHANNELS*CH_WIDTH    enable bits, channel n at
//                                         [n*CH_WIDTH +: CH_WIDTH]
//   ch_en_o     out  CHANNELS             per-channel enable mask
//   ready_o     out  1                    all channels enabled
//   state_o     out  3                    IDLE=0 DEBOUNCE=1 RAMP=2 ON=3
//                                         RAMPDN=4
//
// Configuration macro:
//   MPRJ_LOGIC_HIGH_RAMPDN_EN
//     defined   : hold_i in RAMP/ON clears channels one at a time, highest
//                 first, STAGGER cycles apart (state RAMPDN).
//     undefined : hold_i in RAMP/ON clears every channel on the next edge;
//                 RAMPDN is never entered.
// ---------------------------------------------------------------------------
module mprj_logic_high_seq #(
    parameter int CHANNELS    = 4,
    parameter int CH_WIDTH    = 32,
    parameter int STAGGER     = 16,
    parameter int PG_DEBOUNCE = 8
) (
    input  logic                         wb_clk_i,
    input  logic                         wb_rst_i,
    input  logic                         pwr_good_i,
    input  logic                         hold_i,
    output logic [CHANNELS*CH_WIDTH-1:0] HI,
    output logic [CHANNELS-1:0]          ch_en_o,
    output logic                         ready_o,
    output logic [2:0]                   state_o
);

    // Both counters share one width, sized for the larger of the two limits.
    localparam int CNT_MAX_INT = (STAGGER > PG_DEBOUNCE) ? STAGGER : PG_DEBOUNCE;
    localparam int CW          = $clog2(CNT_MAX_INT + 1);

    localparam logic [CW-1:0] CNT_MAX = CW'(CNT_MAX_INT);
    localparam logic [CW-1:0] DEB_LIM = CW'(PG_DEBOUNCE);
    localparam logic [CW-1:0] STG_LIM = CW'(STAGGER);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DEBOUNCE = 3'd1,
        RAMP     = 3'd2,
        ON       = 3'd3,
        RAMPDN   = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [CHANNELS-1:0]  chEn_q, chEn_d;
    logic                 ready_q, ready_d;
    logic [CW-1:0]        debCnt_q, debCnt_d;
    logic [CW-1:0]        stgCnt_q, stgCnt_d;
    logic                 pgMeta_q, pgSync_q;

    logic [CW-1:0]        debInc;
    logic [CW-1:0]        stgInc;
    logic                 doRelease;
    logic                 doHold;

    // Counters stop at their maximum rather than wrapping back to zero.
    function automatic logic [CW-1:0] satInc(input logic [CW-1:0] v);
        return (v == CNT_MAX) ? v : v + CW'(1);
    endfunction

    // pwr_good_i comes from another power domain; two flops bring it into
    // the wb_clk_i domain before any decision is made on it.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            pgMeta_q <= 1'b0;
            pgSync_q <= 1'b0;
        end else begin
            pgMeta_q <= pwr_good_i;
            pgSync_q <= pgMeta_q;
        end
    end

    // Sequencer state, enable mask, ready flag and both counters.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q  <= IDLE;
            chEn_q   <= '0;
            ready_q  <= 1'b0;
            debCnt_q <= '0;
            stgCnt_q <= '0;
        end else begin
            state_q  <= state_d;
            chEn_q   <= chEn_d;
            ready_q  <= ready_d;
            debCnt_q <= debCnt_d;
            stgCnt_q <= stgCnt_d;
        end
    end

    // Next-state logic. The enable mask is always a thermometer code
    // (channels 0..k on), so ramping up is a shift-in of a one and ramping
    // down is a shift-right; the highest enabled channel is always the one
    // that goes next.
    always_comb begin
        state_d   = state_q;
        chEn_d    = chEn_q;
        ready_d   = ready_q;
        debCnt_d  = debCnt_q;
        stgCnt_d  = stgCnt_q;
        debInc    = satInc(debCnt_q);
        stgInc    = satInc(stgCnt_q);
        doRelease = 1'b0;
        doHold    = 1'b0;

        if ((state_q != IDLE) && !pgSync_q) begin
            // Losing power good overrides hold and any ramp in progress.
            state_d  = IDLE;
            chEn_d   = '0;
            ready_d  = 1'b0;
            debCnt_d = '0;
            stgCnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    chEn_d   = '0;
                    ready_d  = 1'b0;
                    debCnt_d = '0;
                    stgCnt_d = '0;
                    // The cycle that leaves IDLE already has pg_s high, so
                    // it counts as the first debounce cycle.
                    if (pgSync_q && !hold_i) begin
                        debCnt_d = CW'(1);
                        if (CW'(1) >= DEB_LIM) begin
                            doRelease = 1'b1;
                        end else begin
                            state_d = DEBOUNCE;
                        end
                    end
                end

                DEBOUNCE: begin
                    if (hold_i) begin
                        state_d  = IDLE;
                        debCnt_d = '0;
                    end else begin
                        debCnt_d = debInc;
                        if (debInc >= DEB_LIM) begin
                            doRelease = 1'b1;
                        end
                    end
                end

                RAMP: begin
                    if (hold_i) begin
                        doHold = 1'b1;
                    end else begin
                        stgCnt_d = stgInc;
                        if (stgInc >= STG_LIM) begin
                            chEn_d   = (chEn_q << 1) | CHANNELS'(1);
                            stgCnt_d = '0;
                            if (chEn_d[CHANNELS-1]) begin
                                state_d = ON;
                                ready_d = 1'b1;
                            end
                        end
                    end
                end

                ON: begin
                    if (hold_i) begin
                        doHold = 1'b1;
                    end
                end

`ifdef MPRJ_LOGIC_HIGH_RAMPDN_EN
                // Once started the ramp-down runs to completion even if
                // hold_i is released part way through.
                RAMPDN: begin
                    stgCnt_d = stgInc;
                    if (stgInc >= STG_LIM) begin
                        chEn_d   = chEn_q >> 1;
                        stgCnt_d = '0;
                        if (chEn_d == '0) begin
                            state_d = IDLE;
                        end
                    end
                end
`endif

                default: begin
                    state_d  = IDLE;
                    chEn_d   = '0;
                    ready_d  = 1'b0;
                    debCnt_d = '0;
                    stgCnt_d = '0;
                end
            endcase

            // Debounce satisfied: channel 0 goes on and the stagger timer
            // starts from zero. A single-channel build is done straight away.
            if (doRelease) begin
                chEn_d   = CHANNELS'(1);
                debCnt_d = '0;
                stgCnt_d = '0;
                if (CHANNELS == 1) begin
                    state_d = ON;
                    ready_d = 1'b1;
                end else begin
                    state_d = RAMP;
                end
            end

            if (doHold) begin
                ready_d  = 1'b0;
                stgCnt_d = '0;
                debCnt_d = '0;
`ifdef MPRJ_LOGIC_HIGH_RAMPDN_EN
                chEn_d = chEn_q >> 1;
                if (chEn_d == '0) begin
                    state_d = IDLE;
                end else begin
                    state_d = RAMPDN;
                end
`else
                chEn_d  = '0;
                state_d = IDLE;
`endif
            end
        end
    end

    // Every bit of a group follows its channel's mask bit.
    for (genvar g = 0; g < CHANNELS; g++) begin : g_hi
        assign HI[g*CH_WIDTH +: CH_WIDTH] = {CH_WIDTH{chEn_q[g]}};
    end

    assign ch_en_o = chEn_q;
    assign ready_o = ready_q;
    assign state_o = state_q;

endmodule
